nnet_vector_packetizer: RTL and testbench

Store-and-forward packetizer for the transmit side of an NNet RFNoC block. It sits between user-code output (for example an HLS layer's result stream) and the axi_wrapper output port. It buffers one complete vector, then emits it as a single packet. The 128-bit CHDR tuser header is built locally from the payload length, a running sequence number, the settings-bus source SID and `next_dst_sid`, rather than recycled from the input side.

---
 rtl/nnet_vector_packetizer.sv | 103 ++++++++++
 tb/tb_nnet_vector_packetizer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nnet_vector_packetizer.sv
// nnet_vector_packetizer: buffers one vector, then emits it as a CHDR packet with a locally built header.
module nnet_vector_packetizer #(
   parameter int WIDTH        = 16,
   parameter int HEADER_WIDTH = 128,
   parameter int MAX_PKT_SIZE = 256,
   parameter int SR_SRC_SID   = 131
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [15:0]             next_dst_sid,
   input  logic                    set_stb,
   input  logic [7:0]              set_addr,
   input  logic [31:0]             set_data,
   input  logic [2*WIDTH-1:0]      s_axis_data_tdata,
   input  logic                    s_axis_data_tlast,
   input  logic                    s_axis_data_tvalid,
   output logic                    s_axis_data_tready,
   output logic [2*WIDTH-1:0]      o_tdata,
   output logic                    o_tlast,
   output logic                    o_tvalid,
   input  logic                    o_tready,
   output logic [HEADER_WIDTH-1:0] o_tuser
);
   localparam int AW = $clog2(MAX_PKT_SIZE);
   localparam logic [AW:0] ONE = 1;
   typedef enum logic {FILL, DRAIN} state_t;
   state_t state;
   logic [2*WIDTH-1:0] mem [MAX_PKT_SIZE];
   logic [2*WIDTH-1:0] ram_q;
   logic ram_v, ram_last, in_hs, closing, out_en, rd_en, last_hs, unused_bits;
   logic [AW:0] wr_cnt, wr_next, rd_cnt, len;
   logic [11:0] seqnum;
   logic [15:0] src_sid, hdr_len;
   assign unused_bits = ^set_data[31:16];
   assign in_hs   = s_axis_data_tready && s_axis_data_tvalid;
   assign wr_next = wr_cnt + ONE;
   assign closing = in_hs && (s_axis_data_tlast || wr_next == (AW+1)'(MAX_PKT_SIZE));
   assign hdr_len = (16'(wr_next) << 2) + 16'd8;
   // ram_q doubles as the skid slot: it only advances when the output register can take it
   assign out_en  = !o_tvalid || o_tready;
   assign rd_en   = state == DRAIN && rd_cnt != len && (!ram_v || out_en);
   assign last_hs = o_tvalid && o_tready && o_tlast;
   always_ff @(posedge clk) begin
      if (in_hs) mem[wr_cnt[AW-1:0]] <= s_axis_data_tdata;
      if (rd_en) ram_q <= mem[rd_cnt[AW-1:0]];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state              <= FILL;
         s_axis_data_tready <= 1'b1;
         wr_cnt             <= '0;
         rd_cnt             <= '0;
         len                <= '0;
         seqnum             <= '0;
         src_sid            <= '0;
         ram_v              <= 1'b0;
         ram_last           <= 1'b0;
         o_tvalid           <= 1'b0;
         o_tlast            <= 1'b0;
         o_tdata            <= '0;
         o_tuser            <= '0;
      end else begin
         if (set_stb && set_addr == 8'(SR_SRC_SID)) src_sid <= set_data[15:0];
         if (clear) begin
            state              <= FILL;
            s_axis_data_tready <= 1'b1;
            wr_cnt             <= '0;
            rd_cnt             <= '0;
            seqnum             <= '0;
            ram_v              <= 1'b0;
            o_tvalid           <= 1'b0;
            o_tlast            <= 1'b0;
         end else if (state == FILL) begin
            if (in_hs) wr_cnt <= closing ? '0 : wr_next;
            if (closing) begin
               state              <= DRAIN;
               s_axis_data_tready <= 1'b0;
               len                <= wr_next;
               rd_cnt             <= '0;
               o_tuser            <= {2'b00, 1'b0, 1'b0, seqnum, hdr_len, src_sid, next_dst_sid,
                                      {(HEADER_WIDTH-64){1'b0}}};
            end
         end else begin
            if (rd_en) begin
               rd_cnt   <= rd_cnt + ONE;
               ram_last <= rd_cnt == len - ONE;
            end
            ram_v <= rd_en ? 1'b1 : (out_en ? 1'b0 : ram_v);
            if (out_en) begin
               o_tvalid <= ram_v;
               o_tlast  <= ram_v && ram_last;
            end
            if (out_en && ram_v) o_tdata <= ram_q;
            if (last_hs) begin
               state              <= FILL;
               s_axis_data_tready <= 1'b1;
               seqnum             <= seqnum + 12'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_nnet_vector_packetizer.sv
// tb_nnet_vector_packetizer: directed checks of packet framing, headers, timing, stalls, splits and clear.
module tb_nnet_vector_packetizer;
   localparam int SR = 131;
   logic clk = 0, reset = 1, clear = 0, set_stb = 0;
   logic [15:0] next_dst_sid = 16'h0020;
   logic [7:0] set_addr = 0;
   logic [31:0] set_data = 0, s_tdata = 0, o_tdata;
   logic s_tlast = 0, s_tvalid = 0, s_tready, o_tlast, o_tvalid, o_tready;
   logic ready_val = 1, rnd = 0, rbit = 1;
   logic [127:0] o_tuser;
   int tests = 0, fails = 0;
   logic [31:0] qd[$];
   logic [127:0] qu[$];
   logic ql[$];
   logic stall_p = 0, pl;
   logic [31:0] pd;
   logic [127:0] pu;

   nnet_vector_packetizer dut (
      .clk(clk), .reset(reset), .clear(clear), .next_dst_sid(next_dst_sid),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .s_axis_data_tdata(s_tdata), .s_axis_data_tlast(s_tlast),
      .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
      .o_tready(o_tready), .o_tuser(o_tuser));

   always #5 clk = ~clk;
   assign o_tready = rnd ? rbit : ready_val;
   always @(posedge clk) begin
      #1 rbit = 1'($urandom_range(0, 1));
   end

   // Records handshakes and checks that a stalled word stays put.
   always @(negedge clk) begin
      if (o_tvalid && o_tready) begin
         qd.push_back(o_tdata);
         qu.push_back(o_tuser);
         ql.push_back(o_tlast);
      end
      if (stall_p) begin
         tests++;
         assert ({o_tvalid, o_tdata, o_tuser, o_tlast} === {1'b1, pd, pu, pl}) else begin
            fails++;
            $error("FAIL stall_hold: observed v=%b d=%h l=%b expected v=1 d=%h l=%b", o_tvalid, o_tdata, o_tlast, pd, pl);
         end
      end
      stall_p = o_tvalid && !o_tready;
      pd = o_tdata;
      pu = o_tuser;
      pl = o_tlast;
   end

   function automatic logic [127:0] hdr(int seq, int n, logic [15:0] s, logic [15:0] d);
      return {2'b00, 1'b0, 1'b0, 12'(seq), 16'(4 * n + 8), s, d, 64'd0};
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic timeout(string tag);
      tests++;
      fails++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   task automatic push(int base, int n, bit last);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         s_tvalid = 1;
         s_tdata  = 32'(base + i);
         s_tlast  = last && i == n - 1;
         @(negedge clk);
         while (!s_tready && t < 5000) begin
            t++;
            @(negedge clk);
         end
         if (t >= 5000) timeout("push_wait");
         @(posedge clk);
         #1;
      end
      s_tvalid = 0;
      s_tlast  = 0;
   endtask

   task automatic wait_words(int n);
      int t = 0;
      while (qd.size() < n && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (qd.size() < n) timeout("wait_words");
   endtask

   task automatic chk_pkt(string tag, int base, int n, int seq, logic [15:0] s);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_data"}, qd.pop_front(), 128'(base + i));
         chk({tag, "_user"}, qu.pop_front(), hdr(seq, n, s, next_dst_sid));
         chk({tag, "_last"}, 128'(ql.pop_front()), 128'(i == n - 1));
      end
   endtask

   task automatic do_clear();
      clear = 1;
      @(posedge clk);
      #1;
      clear = 0;
      qd.delete();
      qu.delete();
      ql.delete();
   endtask

   task automatic set_reg(int a, int d);
      set_stb  = 1;
      set_addr = 8'(a);
      set_data = 32'(d);
      @(posedge clk);
      #1;
      set_stb = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready", 128'(s_tready), 1);
      chk("rst_tvalid", 128'(o_tvalid), 0);
      chk("rst_tlast", 128'(o_tlast), 0);
      chk("rst_tdata", 128'(o_tdata), 0);
      chk("rst_tuser", o_tuser, 0);
      reset = 0;
      @(posedge clk);
      #1;
      set_reg(SR, 32'h0010);

      // 8-word vector with latency checks
      push(0, 8, 1);
      chk("close_tready", 128'(s_tready), 0);
      chk("close_tvalid0", 128'(o_tvalid), 0);
      @(posedge clk);
      #1;
      chk("close_tvalid1", 128'(o_tvalid), 0);
      @(posedge clk);
      #1;
      chk("close_tvalid2", 128'(o_tvalid), 1);
      chk("first_word", 128'(o_tdata), 0);
      chk("first_user", o_tuser, {2'b00, 1'b0, 1'b0, 12'd0, 16'd40, 16'h0010, 16'h0020, 64'd0});
      wait_words(8);
      chk_pkt("p8", 0, 8, 0, 16'h0010);
      @(posedge clk);
      #1;
      chk("refill_tready", 128'(s_tready), 1);

      // three back-to-back 4-word vectors
      do_clear();
      push(100, 4, 1);
      chk("drain_tready_a", 128'(s_tready), 0);
      push(104, 4, 1);
      chk("drain_tready_b", 128'(s_tready), 0);
      push(108, 4, 1);
      chk("drain_tready_c", 128'(s_tready), 0);
      wait_words(12);
      chk_pkt("b2b0", 100, 4, 0, 16'h0010);
      chk_pkt("b2b1", 104, 4, 1, 16'h0010);
      chk_pkt("b2b2", 108, 4, 2, 16'h0010);

      // 300-word vector split at 256
      do_clear();
      push(1000, 300, 1);
      wait_words(300);
      chk_pkt("split256", 1000, 256, 0, 16'h0010);
      chk_pkt("split44", 1256, 44, 1, 16'h0010);

      // random backpressure
      rnd = 1;
      push(2000, 16, 1);
      wait_words(16);
      rnd = 0;
      chk_pkt("rnd16", 2000, 16, 2, 16'h0010);

      // seqnum wrap with single-word packets
      do_clear();
      for (int j = 0; j < 4097; j++) begin
         push(j, 1, 1);
         wait_words(1);
         chk_pkt("one", j, 1, j % 4096, 16'h0010);
      end

      // clear discards a partial vector; src_sid write mid-drain
      do_clear();
      push(500, 5, 0);
      chk("partial_tready", 128'(s_tready), 1);
      do_clear();
      ready_val = 0;
      push(600, 3, 1);
      set_reg(SR, 32'h0055);
      repeat (5) @(posedge clk);
      #1;
      chk("held_count", 128'(qd.size()), 0);
      ready_val = 1;
      wait_words(3);
      chk_pkt("after_clr", 600, 3, 0, 16'h0010);
      push(700, 1, 1);
      wait_words(1);
      chk_pkt("new_src", 700, 1, 1, 16'h0055);
      repeat (5) @(posedge clk);
      #1;
      chk("no_extra", 128'(qd.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
